room_sequencer: RTL and testbench
=================================

# room_sequencer

Controls room transitions for the overworld. It watches the player's registered `doorcode` and, when a door is crossed, runs a fade-out → room swap → fade-in sequence. It drives the current `room` index to `level_rom` (background and collision) and to the sprite and background draw logic. It also asserts `freeze` to the player and enemy motion logic while a transition is in progress. It sits between the Player block and the `level_rom`/color-mapper consumers and is the only writer of `room`.

## Interface
Parameters:
- `START_ROOM`, 3'd0: room index loaded on reset.
- `FRAMES_PER_STEP`, 4'd2: frame ticks per fade-level step; legal range 1–15.

Ports:
- `Clk`, input, 1: system clock. One clock domain only.
- `Reset`, input, 1: asynchronous, active-high reset.
- `frame_clk`, input, 1: vertical-sync–rate strobe, synchronous to `Clk`. Its rising edge is the frame tick.
- `doorcode`, input, 3: door crossed by the player. 0 = none, 1 = east, 2 = west, 3 = north, 4 = south; 5–7 are invalid.
- `room`, output, 3: current room index. Bit [2] is the row, bits [1:0] are the column.
- `fade_level`, output, 4: brightness. 15 = full, 0 = black.
- `freeze`, output, 1: high while state ≠ IDLE. Motion logic holds position while it is high.
- `room_changed`, output, 1: one-`Clk` pulse in the cycle `room` updates.

## Operation
- Rising-edge detect: a registered copy of `frame_clk` is kept; `tick = frame_clk & ~frame_clk_d`.
- Step divider: a 4-bit counter counts ticks only in FADE_OUT and FADE_IN.
  - `step` pulses on the tick that brings the count to `FRAMES_PER_STEP`; the counter then clears.
  - The counter clears on every state entry.
- State machine:
  - **IDLE**:
    - On a tick with `doorcode` in 1–4, latch `door_q <= doorcode` and go to FADE_OUT.
    - `doorcode` values 0 and 5–7 are ignored.
    - `doorcode` is sampled only on ticks.
  - **FADE_OUT**: on each `step`, `fade_level` decrements by 1. On the step that writes 0, go to SWAP.
  - **SWAP**: exactly one `Clk`. Sets `room <= next_room(room, door_q)` and pulses `room_changed`, then goes to FADE_IN.
  - **FADE_IN**: on each `step`, `fade_level` increments by 1. On the step that writes 15, go to IDLE.
- `next_room` wraps around a 4×2 grid:
  - east: col+1 mod 4
  - west: col−1 mod 4
  - north and south: row toggles
- `doorcode` is ignored in every state except IDLE. A door crossed during a transition is dropped, not queued.
- `fade_level` never underflows or overflows. Arithmetic is 4-bit unsigned, and transitions happen before wrap.

## Timing
- Reset values:
  - `room = START_ROOM`
  - `fade_level = 15`
  - `freeze = 0`
  - `room_changed = 0`
  - state = IDLE, divider = 0, `door_q = 0`
- Latency from tick to state change:
  - Tick cycle N: state becomes FADE_OUT at N+1.
  - `freeze` is registered from next-state, so it is high at N+1.
- `fade_level` update: at the clock edge after the `step` cycle.
- Full transition length: 15 steps out + 1 `Clk` SWAP + 15 steps in, i.e. 30·`FRAMES_PER_STEP` ticks + 1 `Clk`.
- `freeze` falls in the same cycle `fade_level` reaches 15.
- A `frame_clk` held high for multiple cycles produces one tick.
- Reset asserted mid-transition: all outputs return to reset values immediately (asynchronous). `room` reverts to `START_ROOM`, not the pending room.

## Configuration
- `ROOM_FADE_EN`:
  - Defined: full fade sequence as described above.
  - Undefined:
    - FADE_OUT and FADE_IN are not compiled.
    - IDLE goes to SWAP on the qualifying tick, and SWAP returns to IDLE.
    - `room` updates 2 `Clk` after the tick; `room_changed` pulses once.
    - `freeze` is high for 1 cycle, during SWAP.
    - `fade_level` is tied to 15.
    - The step divider is removed.

## Structure
- Package `room_pkg`:
  - `door_e` enum: NONE, EAST, WEST, NORTH, SOUTH.
  - `room_state_e` enum: IDLE, FADE_OUT, SWAP, FADE_IN.
  - `FADE_MAX = 4'd15`.
  - Function `next_room(logic [2:0] room, door_e d)`.
  - Player and `level_rom` import the same door encoding from this package.
- Sub-module `frame_step_gen`: `frame_clk` edge detector plus the step divider. Outputs `tick` and `step`; input `clear`.

## Test plan
All scenarios use `FRAMES_PER_STEP=1` and `ROOM_FADE_EN` defined unless stated.
- **Reset**: assert `Reset` asynchronously between clock edges → `room=0`, `fade_level=15`, `freeze=0`, `room_changed=0` without waiting for a clock edge.
- **East transition**: room 0, `doorcode=1` on a tick → `freeze=1` next cycle. `fade_level` goes 14…0 over 15 ticks, then `room=1` with one `room_changed` pulse. `fade_level` goes 1…15 over 15 ticks; `freeze=0` at 15.
- **Wrap-around**:
  - room 3, east → room 0.
  - room 0, west → room 3.
  - room 1, north → room 5.
  - room 5, south → room 1.
- **Ignored inputs**:
  - `doorcode=2` on ticks during FADE_OUT → destination is still the latched door.
  - `doorcode=6` in IDLE → no state change, `freeze` stays 0.
- **Reset mid-transition**: assert `Reset` at `fade_level=7` in FADE_IN, destination room 1 → `room=0`, `fade_level=15`, `freeze=0`. A new door is accepted on the next tick.
- **`ROOM_FADE_EN` undefined**: room 5, `doorcode=4` on a tick → `room=1` 2 `Clk` later. `freeze` is high for exactly 1 cycle; `fade_level` stays 15 throughout.

Source files
------------

// File: rtl/room_pkg.sv
// Shared room/door encodings and the 4x2 room-grid neighbour function.
// Used by room_sequencer, the player block and level_rom.
package room_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        EAST  = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        SOUTH = 3'd4
    } door_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } room_state_e;

    localparam logic [3:0] FADE_MAX = 4'd15;

    // Room bit [2] is the row, bits [1:0] the column; both axes wrap.
    function automatic logic [2:0] next_room(input logic [2:0] room, input door_e d);
        logic [1:0] col;
        logic       row;
        col = room[1:0];
        row = room[2];
        case (d)
            EAST:         col = col + 2'd1;
            WEST:         col = col - 2'd1;
            NORTH, SOUTH: row = ~row;
            default:      ;
        endcase
        return {row, col};
    endfunction

endpackage

// File: rtl/frame_step_gen.sv
// Frame-tick edge detector plus fade step divider (divider only with ROOM_FADE_EN).
// Latency: tick/step are combinational from frame_clk; no backpressure, clear has priority.
// Backpressure: none; frame ticks arriving outside count_en are ignored by the divider.
module frame_step_gen #(
    parameter logic [3:0] FRAMES_PER_STEP = 4'd2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    input  logic clear,
    input  logic count_en,
    output logic tick,
    output logic step
);

    logic frame_clk_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) frame_clk_d <= 1'b0;
        else       frame_clk_d <= frame_clk;
    end

    assign tick = frame_clk & ~frame_clk_d;

`ifdef ROOM_FADE_EN
    logic [3:0] step_cnt;

    assign step = tick & count_en & ((step_cnt + 4'd1) == FRAMES_PER_STEP);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                  step_cnt <= 4'd0;
        else if (clear || step)     step_cnt <= 4'd0;
        else if (tick && count_en)  step_cnt <= step_cnt + 4'd1;
    end
`else
    assign step = 1'b0;
    wire unused_ctl = clear | count_en | (|FRAMES_PER_STEP);
`endif

endmodule

// File: rtl/room_sequencer.sv
// Room transition sequencer: door tick -> fade out -> room swap -> fade in (ROOM_FADE_EN; else direct swap).
// Latency: freeze rises 1 Clk after the qualifying tick; room updates on the Clk after SWAP.
// Backpressure: none; doors seen outside IDLE are dropped, not queued.
module room_sequencer
    import room_pkg::*;
#(
    parameter logic [2:0] START_ROOM      = 3'd0,
    parameter logic [3:0] FRAMES_PER_STEP = 4'd2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] doorcode,
    output logic [2:0] room,
    output logic [3:0] fade_level,
    output logic       freeze,
    output logic       room_changed
);

    room_state_e state, nxt;
    door_e       door_q;
    logic        tick, step, clear, count_en, door_valid;

    assign door_valid = (doorcode >= 3'd1) && (doorcode <= 3'd4);
    assign clear      = (nxt != state);
`ifdef ROOM_FADE_EN
    assign count_en   = (state == FADE_OUT) || (state == FADE_IN);
`else
    assign count_en   = 1'b0;
    assign fade_level = FADE_MAX;
    wire unused_step  = step;
`endif

    frame_step_gen #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_step_gen (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .clear    (clear),
        .count_en (count_en),
        .tick     (tick),
        .step     (step)
    );

    always_comb begin
        nxt = state;
        case (state)
`ifdef ROOM_FADE_EN
            IDLE:     if (tick && door_valid) nxt = FADE_OUT;
            FADE_OUT: if (step && fade_level == 4'd1) nxt = SWAP;
            SWAP:     nxt = FADE_IN;
            FADE_IN:  if (step && fade_level == FADE_MAX - 4'd1) nxt = IDLE;
`else
            IDLE:     if (tick && door_valid) nxt = SWAP;
            SWAP:     nxt = IDLE;
`endif
            default:  nxt = IDLE;
        endcase
    end

    // freeze is registered from next-state so motion stops on the cycle after the tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            room         <= START_ROOM;
            freeze       <= 1'b0;
            room_changed <= 1'b0;
            door_q       <= NONE;
`ifdef ROOM_FADE_EN
            fade_level   <= FADE_MAX;
`endif
        end else begin
            state        <= nxt;
            freeze       <= (nxt != IDLE);
            room_changed <= 1'b0;
            case (state)
                IDLE: if (nxt != IDLE) door_q <= door_e'(doorcode);
`ifdef ROOM_FADE_EN
                FADE_OUT: if (step) fade_level <= fade_level - 4'd1;
                FADE_IN:  if (step) fade_level <= fade_level + 4'd1;
`endif
                SWAP: begin
                    room         <= next_room(room, door_q);
                    room_changed <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_room_sequencer.sv
module tb_room_sequencer;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [2:0] doorcode;
    logic [2:0] room;
    logic [3:0] fade_level;
    logic       freeze;
    logic       room_changed;

    int errors;
    int checks;
    int rc_count;
    logic [2:0] cur_room;

    typedef struct {
        logic [2:0] door;
        logic [2:0] exp_room;
        bit         valid;
    } vec_t;

    vec_t vecs[18];

    room_sequencer #(
        .START_ROOM     (3'd0),
        .FRAMES_PER_STEP(4'd1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .doorcode    (doorcode),
        .room        (room),
        .fade_level  (fade_level),
        .freeze      (freeze),
        .room_changed(room_changed)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (room_changed === 1'b1) rc_count++;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_frame(input int hold);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (hold) @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    task automatic run_ignored(input logic [2:0] door);
        int rc0;
        rc0 = rc_count;
        doorcode = door;
        pulse_frame(1);
        doorcode = 3'd0;
        check("ign_freeze", {7'd0, freeze}, 8'd0);
        repeat (3) @(negedge Clk);
        check("ign_room", {5'd0, room}, {5'd0, cur_room});
        check("ign_fade", {4'd0, fade_level}, 8'd15);
        check("ign_rc", 8'(rc_count - rc0), 8'd0);
    endtask

`ifdef ROOM_FADE_EN
    task automatic run_door(input logic [2:0] door, input logic [2:0] exp_room, input int hold);
        int rc0;
        rc0 = rc_count;
        doorcode = door;
        pulse_frame(hold);
        doorcode = (door == 3'd2) ? 3'd1 : 3'd2;
        check("go_freeze", {7'd0, freeze}, 8'd1);
        check("go_fade", {4'd0, fade_level}, 8'd15);
        for (int i = 1; i <= 15; i++) begin
            pulse_frame(1);
            check("fade_out", {4'd0, fade_level}, 8'(15 - i));
        end
        check("room_pre_swap", {5'd0, room}, {5'd0, cur_room});
        doorcode = 3'd0;
        @(negedge Clk);
        check("room_new", {5'd0, room}, {5'd0, exp_room});
        check("room_changed", {7'd0, room_changed}, 8'd1);
        for (int i = 1; i <= 15; i++) begin
            pulse_frame(1);
            check("fade_in", {4'd0, fade_level}, 8'(i));
            check("fade_in_freeze", {7'd0, freeze}, (i < 15) ? 8'd1 : 8'd0);
        end
        check("rc_once", 8'(rc_count - rc0), 8'd1);
    endtask
`else
    task automatic run_door(input logic [2:0] door, input logic [2:0] exp_room, input int hold);
        int rc0;
        rc0 = rc_count;
        @(negedge Clk);
        doorcode  = door;
        frame_clk = 1'b1;
        @(negedge Clk);
        check("swap_freeze", {7'd0, freeze}, 8'd1);
        check("swap_room_old", {5'd0, room}, {5'd0, cur_room});
        check("swap_fade", {4'd0, fade_level}, 8'd15);
        @(negedge Clk);
        check("room_new", {5'd0, room}, {5'd0, exp_room});
        check("room_changed", {7'd0, room_changed}, 8'd1);
        check("post_freeze", {7'd0, freeze}, 8'd0);
        @(negedge Clk);
        check("rc_low", {7'd0, room_changed}, 8'd0);
        check("idle_freeze", {7'd0, freeze}, 8'd0);
        // frame_clk was held high for several cycles with a valid door: still one swap
        repeat (hold) @(negedge Clk);
        frame_clk = 1'b0;
        doorcode  = 3'd0;
        check("rc_once", 8'(rc_count - rc0), 8'd1);
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        rc_count  = 0;
        Reset     = 1'b0;
        frame_clk = 1'b0;
        doorcode  = 3'd0;

        repeat (2) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("rst_room", {5'd0, room}, 8'd0);
        check("rst_fade", {4'd0, fade_level}, 8'd15);
        check("rst_freeze", {7'd0, freeze}, 8'd0);
        check("rst_rc", {7'd0, room_changed}, 8'd0);
        @(negedge Clk);
        Reset    = 1'b0;
        cur_room = 3'd0;

        vecs[0]  = '{3'd1, 3'd1, 1'b1};
        vecs[1]  = '{3'd1, 3'd2, 1'b1};
        vecs[2]  = '{3'd1, 3'd3, 1'b1};
        vecs[3]  = '{3'd1, 3'd0, 1'b1};
        vecs[4]  = '{3'd2, 3'd3, 1'b1};
        vecs[5]  = '{3'd2, 3'd2, 1'b1};
        vecs[6]  = '{3'd2, 3'd1, 1'b1};
        vecs[7]  = '{3'd3, 3'd5, 1'b1};
        vecs[8]  = '{3'd4, 3'd1, 1'b1};
        vecs[9]  = '{3'd3, 3'd5, 1'b1};
        vecs[10] = '{3'd6, 3'd5, 1'b0};
        vecs[11] = '{3'd1, 3'd6, 1'b1};
        vecs[12] = '{3'd1, 3'd7, 1'b1};
        vecs[13] = '{3'd1, 3'd4, 1'b1};
        vecs[14] = '{3'd2, 3'd7, 1'b1};
        vecs[15] = '{3'd0, 3'd7, 1'b0};
        vecs[16] = '{3'd7, 3'd7, 1'b0};
        vecs[17] = '{3'd4, 3'd3, 1'b1};

        for (int v = 0; v < 18; v++) begin
            if (vecs[v].valid) run_door(vecs[v].door, vecs[v].exp_room, (v == 0) ? 3 : 1);
            else               run_ignored(vecs[v].door);
            cur_room = vecs[v].exp_room;
        end

`ifdef ROOM_FADE_EN
        // Reset mid FADE_IN with destination room 1
        @(negedge Clk);
        #2 Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        doorcode = 3'd1;
        pulse_frame(1);
        doorcode = 3'd0;
        repeat (15) pulse_frame(1);
        @(negedge Clk);
        repeat (7) pulse_frame(1);
        check("mid_fade", {4'd0, fade_level}, 8'd7);
        check("mid_room", {5'd0, room}, 8'd1);
        check("mid_freeze", {7'd0, freeze}, 8'd1);
        #2 Reset = 1'b1;
        #1;
        check("mrst_room", {5'd0, room}, 8'd0);
        check("mrst_fade", {4'd0, fade_level}, 8'd15);
        check("mrst_freeze", {7'd0, freeze}, 8'd0);
        @(negedge Clk);
        Reset = 1'b0;
        doorcode = 3'd1;
        pulse_frame(1);
        doorcode = 3'd0;
        check("after_rst_freeze", {7'd0, freeze}, 8'd1);
`else
        // Reset during SWAP: pending room must not land
        @(negedge Clk);
        doorcode  = 3'd1;
        frame_clk = 1'b1;
        @(negedge Clk);
        check("mid_freeze", {7'd0, freeze}, 8'd1);
        #2 Reset = 1'b1;
        #1;
        check("mrst_room", {5'd0, room}, 8'd0);
        check("mrst_fade", {4'd0, fade_level}, 8'd15);
        check("mrst_freeze", {7'd0, freeze}, 8'd0);
        @(negedge Clk);
        Reset     = 1'b0;
        frame_clk = 1'b0;
        doorcode  = 3'd0;
        @(negedge Clk);
        doorcode  = 3'd1;
        frame_clk = 1'b1;
        @(negedge Clk);
        check("after_rst_freeze", {7'd0, freeze}, 8'd1);
        @(negedge Clk);
        check("after_rst_room", {5'd0, room}, 8'd1);
        frame_clk = 1'b0;
        doorcode  = 3'd0;
`endif

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
